// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and width/limit helpers for the serial FIR.
package fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fir_state_t;
  function automatic int acc_width(int dw, int cw, int taps);
    return dw + cw + $clog2(taps);
  endfunction
  function automatic logic signed [63:0] sat_max(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate with synchronous clear and enable.
module fir_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = 36
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [COEF_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);
  logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod;
  assign prod = a * b;
  always_ff @(posedge clk)
    if (reset || clr) acc <= '0;
    else if (en) acc <= acc + ACC_WIDTH'(prod);
endmodule

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed FIR sharing one MAC across all taps,
// with valid/ready streaming, addressed coefficient writes and round/saturate.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 9,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         coef_wr,
  input  logic [$clog2(TAPS)-1:0]      coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  input  logic                         out_ready,
  output logic                         busy
);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS);
  localparam int RW = ACC_WIDTH + 1;
  localparam int KW = $clog2(TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam logic signed [RW-1:0] RND = (SHIFT == 0) ? RW'(0) : RW'(1) << (SHIFT == 0 ? 0 : SHIFT - 1);
  fir_state_t state, state_nx;
  logic [KW-1:0] k;
  logic [TAPS-1:0][DATA_WIDTH-1:0] x;
  logic [TAPS-1:0][COEF_WIDTH-1:0] b;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [RW-1:0] sum, r;
  logic signed [63:0] r_ext;
  logic accept, hi, lo;
  assign in_ready  = state == IDLE && !reset;
  assign accept    = in_valid && in_ready;
  assign busy      = state != IDLE;
  assign out_valid = state == OUT;
  // one guard bit so adding the rounding constant can never wrap
  assign sum   = {acc[ACC_WIDTH-1], acc} + RND;
  assign r     = sum >>> SHIFT;
  assign r_ext = 64'(r);
  assign hi    = r_ext > sat_max(OUT_WIDTH);
  assign lo    = r_ext < sat_min(OUT_WIDTH);
  fir_mac #(.DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state == MAC),
    .a     ($signed(x[k])),
    .b     ($signed(b[k])),
    .acc   (acc)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = accept ? MAC : IDLE;
      MAC:   state_nx = k == K_LAST ? ROUND : MAC;
      ROUND: state_nx = OUT;
      OUT:   state_nx = out_ready ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      x        <= '0;
      b        <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && coef_wr && 32'(coef_addr) < TAPS) b[coef_addr] <= coef_data;
      k <= accept ? '0 : state == MAC ? k + KW'(1) : k;
      if (accept) x <= {x[TAPS-2:0], in_data};
      if (state == ROUND) begin
        out_data <= hi ? OUT_WIDTH'(sat_max(OUT_WIDTH)) : lo ? OUT_WIDTH'(sat_min(OUT_WIDTH)) : OUT_WIDTH'(r_ext);
        out_sat  <= hi || lo;
      end
    end
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: random and directed checks of two FIR instances (SHIFT 0 and 1) against a dot-product model.
module tb_fir_serial_mac;
  localparam int T = 5;
  logic clk = 0, reset = 1;
  logic coef_wr = 0;
  logic [2:0] coef_addr = 0;
  logic signed [15:0] coef_data = 0, in_data = 0;
  logic in_valid = 0, out_ready = 1;
  logic in_ready0, out_valid0, out_sat0, busy0;
  logic in_ready1, out_valid1, out_sat1, busy1;
  logic signed [15:0] out_data0, out_data1;
  longint mx[T], mb[T];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  fir_serial_mac #(.DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(T), .OUT_WIDTH(16), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_data(out_data0), .out_sat(out_sat0), .out_ready(out_ready), .busy(busy0));
  fir_serial_mac #(.DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(T), .OUT_WIDTH(16), .SHIFT(1)) u_dut1 (
    .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .out_sat(out_sat1), .out_ready(out_ready), .busy(busy1));
  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  // dot product of history and coefficients, then round-half-up and clip
  function automatic longint model(input int sh, output logic sat);
    longint acc = 0, r;
    for (int i = 0; i < T; i++) acc += mx[i] * mb[i];
    r = sh > 0 ? (acc + (longint'(1) <<< (sh - 1))) >>> sh : acc;
    sat = r > 32767 || r < -32768;
    return r > 32767 ? 32767 : r < -32768 ? -32768 : r;
  endfunction
  task automatic write_coef(input int a, input int v);
    coef_wr = 1; coef_addr = 3'(a); coef_data = 16'(v);
    @(posedge clk); #1;
    coef_wr = 0;
    if (a < T) mb[a] = v;
  endtask
  task automatic run(input int s, input int hold, input bit wr_acc, input int wa, input int wv, input bit wr_mid);
    longint e0, e1;
    logic s0, s1;
    logic signed [15:0] held;
    int n;
    check("in_ready0", in_ready0, 1);
    check("in_ready1", in_ready1, 1);
    out_ready = hold == 0;
    in_valid = 1; in_data = 16'(s);
    if (wr_acc) begin coef_wr = 1; coef_addr = 3'(wa); coef_data = 16'(wv); end
    @(posedge clk); #1;
    in_valid = 0; coef_wr = 0;
    if (wr_acc && wa < T) mb[wa] = wv;
    for (int i = T - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = s;
    e0 = model(0, s0);
    e1 = model(1, s1);
    if (wr_mid) begin coef_wr = 1; coef_addr = 0; coef_data = 16'sd1234; end
    n = 0;
    while (!out_valid0 && n < 40) begin
      @(posedge clk); #1;
      coef_wr = 0;
      n++;
    end
    coef_wr = 0;
    check("latency", n, T + 1);
    check("valid1", out_valid1, 1);
    check("data0", out_data0, e0);
    check("sat0", out_sat0, s0);
    check("data1", out_data1, e1);
    check("sat1", out_sat1, s1);
    held = out_data0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid0, 1);
      check("hold_data", out_data0, held);
      check("hold_ready", in_ready0, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("release_valid", out_valid0, 0);
    check("release_ready", in_ready0, 1);
  endtask
  task automatic reset_mid();
    bit seen = 0;
    in_valid = 1; in_data = 16'sd100;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    check("mid_busy", busy0, 1);
    reset = 1; #1;
    check("rst_ready", in_ready0, 0);
    @(posedge clk); #1;
    check("rst_busy0", busy0, 0);
    check("rst_busy1", busy1, 0);
    reset = 0; #1;
    check("rst_release_ready", in_ready0, 1);
    for (int i = 0; i < T + 4; i++) begin
      @(posedge clk); #1;
      seen |= out_valid0 | out_valid1;
    end
    check("rst_no_output", seen, 0);
    for (int i = 0; i < T; i++) begin mx[i] = 0; mb[i] = 0; end
  endtask
  initial begin
    for (int i = 0; i < T; i++) begin mx[i] = 0; mb[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", in_ready0, 0);
    check("reset_busy", busy0, 0);
    check("reset_valid", out_valid0, 0);
    check("reset_data", out_data0, 0);
    check("reset_sat", out_sat0, 0);
    reset = 0; #1;
    check("post_reset_ready", in_ready0, 1);
    for (int i = 0; i < 4; i++) write_coef(i, i + 1);
    run(1, 0, 0, 0, 0, 0);
    check("impulse_first", out_data0, 1);
    for (int i = 0; i < 4; i++) run(0, 0, 0, 0, 0, 0);
    check("impulse_tail", out_data0, 0);
    run(7, 0, 1, 5, 77, 0);
    run(-9, 0, 1, 7, 55, 1);
    run(0, 0, 0, 0, 0, 1);
    run(1, 0, 1, 0, 10, 0);
    for (int i = 0; i < T; i++) write_coef(i, 32767);
    for (int i = 0; i < T; i++) run(32767, 0, 0, 0, 0, 0);
    check("sat_pos", out_data0, 32767);
    for (int i = 0; i < T; i++) run(-32768, 0, 0, 0, 0, 0);
    check("sat_neg", out_data0, -32768);
    write_coef(0, 1);
    for (int i = 1; i < T; i++) write_coef(i, 0);
    run(3, 0, 0, 0, 0, 0);
    check("round_p3", out_data1, 2);
    run(-3, 0, 0, 0, 0, 0);
    check("round_m3", out_data1, -1);
    run(2, 0, 0, 0, 0, 0);
    check("round_p2", out_data1, 1);
    run(5, 10, 0, 0, 0, 0);
    run(6, 0, 0, 0, 0, 0);
    reset_mid();
    run(1, 0, 0, 0, 0, 0);
    check("post_reset_impulse", out_data0, 0);
    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(2) == 0) write_coef($urandom_range(7), int'($urandom_range(65535)) - 32768);
      run(j % 4 == 0 ? int'($urandom_range(400)) - 200 : int'($urandom_range(65535)) - 32768,
          $urandom_range(3), 1'($urandom_range(1)), $urandom_range(7),
          j % 3 == 0 ? int'($urandom_range(64)) - 32 : int'($urandom_range(65535)) - 32768,
          1'($urandom_range(1)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
